// File: rtl/wdt_pkg.sv
// wdt_pkg
//   Shared definitions for the watchdog reset-request block:
//   - wdt_state_e : 3-bit FSM state encoding (DISABLED, ARMED, WARN, FIRE, HOLD)
//   - DEF_*       : default timing constants for top-level instantiations
package wdt_pkg;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARMED    = 3'd1,
        WARN     = 3'd2,
        FIRE     = 3'd3,
        HOLD     = 3'd4
    } wdt_state_e;

    localparam int unsigned DEF_TIMEOUT     = 50_000_000;
    localparam int unsigned DEF_WARN_CYCLES = 5_000_000;
    localparam int unsigned DEF_PULSE_LEN   = 16;
    localparam int unsigned DEF_CNT_W       = 26;

endpackage

// File: rtl/watchdog_reset_req_edge_sync.sv
// edge_sync
//   Registers an asynchronous level once, delays it by one more register and
//   reports a single-cycle rising-edge event (q1 & ~q2). A held level yields
//   exactly one event.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   d_i    : level input
//   rise_o : one-cycle rising-edge event
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic q1_q;
    logic q2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign rise_o = q1_q & ~q2_q;

endmodule

// File: rtl/watchdog_reset_req.sv
// watchdog_reset_req
//   Watchdog that originates reset requests for the delayed-reset generator.
//   A missed kick within TIMEOUT cycles, or a SwReq rising edge, produces a
//   PULSE_LEN-cycle ResetReq; the block then parks in HOLD until Reset.
//   Clk      : system clock
//   Reset    : synchronous active-high reset (delayed-reset output)
//   Enable   : level, 1 = watchdog armed
//   Kick     : rising edge restarts the timeout
//   SwReq    : rising edge forces a reset request
//   ResetReq : registered request to the reset generator
//   Warning  : registered, high during the last WARN_CYCLES before timeout
//   Fired    : registered, high in FIRE and HOLD
//   Count    : current timeout counter value
module watchdog_reset_req
    import wdt_pkg::*;
#(
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned WARN_CYCLES = DEF_WARN_CYCLES,
    parameter int unsigned PULSE_LEN   = DEF_PULSE_LEN,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Kick,
    input  logic             SwReq,
    output logic             ResetReq,
    output logic             Warning,
    output logic             Fired,
    output logic [CNT_W-1:0] Count
);

    localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [CNT_W-1:0] WARN_AT    = CNT_W'(TIMEOUT - WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRE_AT    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0]    PULSE_ONE  = PW'(1);

    logic kick_evt;
    logic sw_rise;

    edge_sync u_kick_sync (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (Kick),
        .rise_o (kick_evt)
    );

    edge_sync u_swreq_sync (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (SwReq),
        .rise_o (sw_rise)
    );

    wdt_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic             sw_evt_q;
    logic             resetreq_q, warning_q, fired_q;

    // The SwReq event is retimed by one register so a request first sampled
    // at edge n raises ResetReq after edge n+2, one cycle behind the kick path.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = pulse_q;
        unique case (state_q)
            DISABLED: begin
                count_d = '0;
                if (sw_evt_q) begin
                    state_d = FIRE;
                    pulse_d = '0;
                end else if (Enable) begin
                    state_d = ARMED;
                end
            end
            ARMED, WARN: begin
                if (sw_evt_q) begin
                    state_d = FIRE;
                    pulse_d = '0;
                end else if (!Enable) begin
                    state_d = DISABLED;
                    count_d = '0;
                end else if (kick_evt) begin
                    state_d = ARMED;
                    count_d = '0;
                end else if (state_q == WARN && count_q == FIRE_AT) begin
                    // Count stays at TIMEOUT-1 so it can never wrap.
                    state_d = FIRE;
                    pulse_d = '0;
                end else begin
                    if (state_q == ARMED && count_q == WARN_AT) begin
                        state_d = WARN;
                    end
                    count_d = count_q + CNT_ONE;
                end
            end
            FIRE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = HOLD;
                end else begin
                    pulse_d = pulse_q + PULSE_ONE;
                end
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: begin
                state_d = DISABLED;
                count_d = '0;
                pulse_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state transition edge rather than lagging it by a cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= DISABLED;
            count_q    <= '0;
            pulse_q    <= '0;
            sw_evt_q   <= 1'b0;
            resetreq_q <= 1'b0;
            warning_q  <= 1'b0;
            fired_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            sw_evt_q   <= sw_rise;
            resetreq_q <= (state_d == FIRE);
            warning_q  <= (state_d == WARN);
            fired_q    <= (state_d == FIRE) || (state_d == HOLD);
        end
    end

    assign ResetReq = resetreq_q;
    assign Warning  = warning_q;
    assign Fired    = fired_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_watchdog_reset_req.sv
module tb_watchdog_reset_req;

    localparam int unsigned T_TIMEOUT = 20;
    localparam int unsigned T_WARN    = 5;
    localparam int unsigned T_PULSE   = 4;
    localparam int unsigned T_CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               kick;
    logic               swreq;
    logic               resetreq;
    logic               warning;
    logic               fired;
    logic [T_CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    watchdog_reset_req #(
        .TIMEOUT     (T_TIMEOUT),
        .WARN_CYCLES (T_WARN),
        .PULSE_LEN   (T_PULSE),
        .CNT_W       (T_CNT_W)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Enable   (en),
        .Kick     (kick),
        .SwReq    (swreq),
        .ResetReq (resetreq),
        .Warning  (warning),
        .Fired    (fired),
        .Count    (count)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        en    = 1'b0;
        kick  = 1'b0;
        swreq = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Enable must already be 1 with the FSM in DISABLED. k counts edges after
    // the arming edge (k=0 -> Count=0).
    task automatic run_full_timeout(input int hold_cycles);
        logic exp_w, exp_r, exp_f;
        for (int k = 0; k < 24 + hold_cycles; k++) begin
            tick();
            exp_w = (k >= 15 && k <= 19);
            exp_r = (k >= 20 && k <= 23);
            exp_f = (k >= 20);
            n_checks++;
            if (warning !== exp_w) begin
                n_fail++;
                $display("FAIL timeout_warning k=%0d: got %b expected %b", k, warning, exp_w);
            end
            n_checks++;
            if (resetreq !== exp_r) begin
                n_fail++;
                $display("FAIL timeout_resetreq k=%0d: got %b expected %b", k, resetreq, exp_r);
            end
            n_checks++;
            if (fired !== exp_f) begin
                n_fail++;
                $display("FAIL timeout_fired k=%0d: got %b expected %b", k, fired, exp_f);
            end
            if (k <= 19) begin
                n_checks++;
                if (count !== T_CNT_W'(k)) begin
                    n_fail++;
                    $display("FAIL timeout_count k=%0d: got %0d expected %0d", k, count, k);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({resetreq, warning, fired} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000", {resetreq, warning, fired});
        end
        n_checks++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        // Stays idle while disabled.
        repeat (5) tick();
        n_checks++;
        if ({resetreq, warning, fired, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b/%b/%b/%0d expected all 0", resetreq, warning, fired, count);
        end
    endtask

    task automatic test_arm_no_kick();
        apply_reset();
        en = 1'b1;
        run_full_timeout(50);
    endtask

    task automatic test_periodic_kick();
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            kick = (c % 10 == 0);
            tick();
            n_checks++;
            if (warning !== 1'b0 || resetreq !== 1'b0) begin
                n_fail++;
                $display("FAIL periodic_outputs c=%0d: got w=%b r=%b expected 0/0", c, warning, resetreq);
            end
            n_checks++;
            if (count > 11) begin
                n_fail++;
                $display("FAIL periodic_count c=%0d: got %0d expected <= 11", c, count);
            end
        end
        kick = 1'b0;
    endtask

    task automatic test_kick_in_warn();
        // Kick in the middle of the warning window.
        apply_reset();
        en = 1'b1;
        repeat (17) tick();            // k = 16
        n_checks++;
        if (warning !== 1'b1 || count !== 8'd16) begin
            n_fail++;
            $display("FAIL warn_pre_kick: got w=%b count=%0d expected 1/16", warning, count);
        end
        kick = 1'b1;
        tick();                        // kick first sampled, count 17
        tick();                        // kick event applied
        kick = 1'b0;
        n_checks++;
        if (warning !== 1'b0 || count !== 8'd0 || resetreq !== 1'b0) begin
            n_fail++;
            $display("FAIL warn_kick: got w=%b count=%0d r=%b expected 0/0/0", warning, count, resetreq);
        end

        // Kick event lands on the TIMEOUT-1 compare cycle.
        apply_reset();
        en = 1'b1;
        repeat (19) tick();            // k = 18
        kick = 1'b1;
        tick();                        // k = 19, kick first sampled
        n_checks++;
        if (count !== 8'd19 || warning !== 1'b1) begin
            n_fail++;
            $display("FAIL race_pre: got count=%0d w=%b expected 19/1", count, warning);
        end
        tick();
        kick = 1'b0;
        n_checks++;
        if (count !== 8'd0 || warning !== 1'b0 || resetreq !== 1'b0 || fired !== 1'b0) begin
            n_fail++;
            $display("FAIL race_kick: got count=%0d w=%b r=%b f=%b expected 0/0/0/0", count, warning, resetreq, fired);
        end
        for (int k = 1; k < 20; k++) begin
            tick();
            n_checks++;
            if (resetreq !== 1'b0 || count !== T_CNT_W'(k)) begin
                n_fail++;
                $display("FAIL race_restart k=%0d: got r=%b count=%0d expected 0/%0d", k, resetreq, count, k);
            end
        end
    endtask

    task automatic test_swreq_disabled();
        logic exp_r, exp_f;
        apply_reset();
        en = 1'b0;
        swreq = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 10) swreq = 1'b0;
            exp_r = (j >= 3 && j <= 6);
            exp_f = (j >= 3);
            n_checks++;
            if (resetreq !== exp_r) begin
                n_fail++;
                $display("FAIL swreq_resetreq j=%0d: got %b expected %b", j, resetreq, exp_r);
            end
            n_checks++;
            if (fired !== exp_f || warning !== 1'b0) begin
                n_fail++;
                $display("FAIL swreq_fired j=%0d: got f=%b w=%b expected %b/0", j, fired, warning, exp_f);
            end
        end
    endtask

    task automatic test_disable_mid_count();
        apply_reset();
        en = 1'b1;
        repeat (18) tick();            // k = 17
        n_checks++;
        if (warning !== 1'b1 || count !== 8'd17) begin
            n_fail++;
            $display("FAIL disable_pre: got w=%b count=%0d expected 1/17", warning, count);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (warning !== 1'b0 || count !== 8'd0 || resetreq !== 1'b0 || fired !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_now: got w=%b count=%0d r=%b f=%b expected 0/0/0/0", warning, count, resetreq, fired);
        end
        tick();
        n_checks++;
        if (count !== 8'd0) begin
            n_fail++;
            $display("FAIL disable_hold: got count=%0d expected 0", count);
        end
        en = 1'b1;
        run_full_timeout(3);
    endtask

    task automatic test_reset_mid_fire();
        apply_reset();
        en = 1'b1;
        repeat (22) tick();            // k = 21, second ResetReq cycle
        n_checks++;
        if (resetreq !== 1'b1 || fired !== 1'b1) begin
            n_fail++;
            $display("FAIL midfire_pre: got r=%b f=%b expected 1/1", resetreq, fired);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({resetreq, warning, fired} !== 3'b000 || count !== '0) begin
            n_fail++;
            $display("FAIL midfire_reset: got r=%b w=%b f=%b count=%0d expected 0/0/0/0", resetreq, warning, fired, count);
        end
        rst = 1'b0;
        run_full_timeout(10);
    endtask

    initial begin
        test_reset();
        test_arm_no_kick();
        test_periodic_kick();
        test_kick_in_warn();
        test_swreq_disabled();
        test_disable_mid_count();
        test_reset_mid_fire();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watchdog_reset_req.md
# watchdog_reset_req

Watchdog that originates reset requests for the delayed-reset generator. Its `ResetReq` output drives the generator's button-style request input (`BTNS`), and it is itself reset by the generator's `Reset` output. A missed software/FSM kick within `TIMEOUT` cycles, or an explicit `SwReq` edge, produces a `PULSE_LEN`-cycle request. The block then parks until the resulting system reset arrives.

## Interface
- `TIMEOUT`, 50_000_000: cycles from arm/kick to `ResetReq` assertion.
- `WARN_CYCLES`, 5_000_000: length of the `Warning` window before timeout.
- `PULSE_LEN`, 16: `ResetReq` high time, in cycles.
- `CNT_W`, 26: width of the timeout counter.
- Parameter constraints: 1 ≤ `WARN_CYCLES` < `TIMEOUT` < 2^`CNT_W`; `PULSE_LEN` ≥ 1.

- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset (the delayed-reset output).
- `Enable`  in  1  level; 1 = watchdog armed.
- `Kick`  in  1  rising edge restarts the timeout.
- `SwReq`  in  1  rising edge forces an immediate reset request.
- `ResetReq`  out  1  registered request to the reset generator.
- `Warning`  out  1  registered; high during the last `WARN_CYCLES` before timeout.
- `Fired`  out  1  registered; high in FIRE and HOLD.
- `Count`  out  `CNT_W`  current timeout counter value.

## Operation
- Input conditioning:
  - `Kick` and `SwReq` are each registered once (localised), then edge-detected against a second register.
  - An event is `q1 & ~q2`, so a held level produces exactly one event.
- Reset values:
  - State = DISABLED.
  - `Count` = 0; pulse counter = 0.
  - Edge registers = 0.
  - `ResetReq`, `Warning`, `Fired` = 0.
- States:
  - **DISABLED**
    - `Count` held at 0; all outputs low.
    - `Enable`=1 → ARMED with `Count`=0.
  - **ARMED**
    - `Count` increments each cycle.
    - Kick event → `Count`=0.
    - `Count` == `TIMEOUT`-`WARN_CYCLES`-1 → WARN.
    - `Enable`=0 → DISABLED.
  - **WARN**
    - `Warning`=1; `Count` increments.
    - Kick event → ARMED with `Count`=0.
    - `Count` == `TIMEOUT`-1 → FIRE.
    - `Enable`=0 → DISABLED.
  - **FIRE**
    - `ResetReq`=1, `Fired`=1.
    - The pulse counter counts 0..`PULSE_LEN`-1, then → HOLD.
    - `Enable`, Kick and `SwReq` are ignored.
  - **HOLD**
    - `ResetReq`=0, `Fired`=1.
    - Terminal state: left only via `Reset`. All inputs are ignored.
- `SwReq` event in DISABLED, ARMED or WARN → FIRE. The pulse counter is cleared and `Count` is frozen.
- Priority, highest first: `Reset` > `SwReq` event > `Enable`=0 > Kick event > timeout/warn compare.
  - A kick on the same cycle as the `TIMEOUT`-1 compare wins: no fire occurs.
- `Count` never wraps: the FIRE transition occurs before saturation.
- `Reset` asserted mid-FIRE truncates the pulse: `ResetReq`=0 on the next edge.

## Timing
- Timeout:
  - Entering ARMED at edge e (`Count`=0) gives `Warning`↑ after edge e+`TIMEOUT`-`WARN_CYCLES`.
  - `ResetReq`↑ follows after edge e+`TIMEOUT`.
  - `Warning` therefore lasts exactly `WARN_CYCLES` cycles, and falls on the same edge that `ResetReq` rises.
- Kick latency:
  - `Kick`=1 first sampled at edge n means `Count`=0 after edge n+1.
  - The full `TIMEOUT` restarts from there.
- `SwReq` latency: first sampled at edge n means `ResetReq`=1 after edge n+2.
- `ResetReq` width: exactly `PULSE_LEN` cycles; then it stays low until `Reset`.
- Outputs are registered: no combinational path from any input to any output.
- `Enable` is sampled directly: a 1→0 transition is effective at the next edge.

## Structure
- Shared package (`wdt_pkg`) holds:
  - The state encoding localparams: DISABLED, ARMED, WARN, FIRE, HOLD; 3-bit.
  - The default `TIMEOUT`/`WARN_CYCLES`/`PULSE_LEN` constants used by top-level instantiations.
- One sub-module, `edge_sync`:
  - A localising register plus a delay register, with rising-edge output and synchronous reset.
  - Instantiated twice, for `Kick` and `SwReq`.
- The remaining logic is a single FSM, the timeout counter and the pulse counter in the top module.

## Test plan
Test parameters: `TIMEOUT`=20, `WARN_CYCLES`=5, `PULSE_LEN`=4.
- **Arm, no kick:** release `Reset`, `Enable`=1 → `Warning` high for 5 cycles (from 15 cycles after arm) → `ResetReq` high exactly 4 cycles → `Fired` stays 1, `ResetReq` stays 0 for 50 cycles.
- **Periodic kick:** `Kick` pulse every 10 cycles for 200 cycles → `Warning` and `ResetReq` never assert; `Count` ≤ 11.
- **Kick in warn / same-cycle race:** kick during `Warning`, and separately kick sampled so that its event lands on `Count`=19 → `Warning` drops, `Count`=0, no `ResetReq`.
- **SwReq while disabled:** `Enable`=0, `SwReq` held high 10 cycles → single 4-cycle `ResetReq` starting 2 cycles after first sample; no second pulse.
- **Disable mid-count:** `Enable`→0 at `Count`=17 (`Warning` high) → next edge DISABLED, `Warning`=0, `Count`=0; re-enable gives a full 20-cycle timeout.
- **Reset mid-FIRE:** assert `Reset` on the 2nd `ResetReq` cycle → all outputs 0 next edge, state DISABLED; re-arm behaves as scenario 1.
